// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit stage.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Rounded so that e.g. 50 MHz / 115200 lands on the nearest whole period.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte_baud_gen.sv
// Bit-period counter: bit_end pulses on the last cycle of each serial bit.
// Holding clear keeps the counter at zero so the next bit starts a full period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter fed by the keypad ASCII decoder's start pulse.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1 framing).
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BCW = $clog2(DATA_BITS);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   start_q;
    logic                   start_rise;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign start_rise = start & ~start_q;

    // Counter is parked at zero in IDLE so START always gets a full bit period.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (FPGA_CLK1_50),
        .rst_n   (reset_n),
        .clear   (state_q == IDLE),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d   = START;
                    shift_d   = data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state so reset forces the line idle at once.
    always_comb begin
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == STOP) && bit_end;

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            start_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            start_q   <= start;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte: a line monitor decodes frames and
// compares them against a queue of expected bytes pushed when stimulus is driven.
module tb_uart_tx_byte;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    typedef struct {
        logic [7:0] d;
        logic       par;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] data;
    logic       start;
    logic       tx;
    logic       busy;
    logic       done;

    int   checks = 0;
    int   errors = 0;
    int   frames_exp = 0;
    int   frames_rx = 0;
    vec_t exp_q[$];
    vec_t vecs[8];

    uart_tx_byte #(
        .CLK_HZ       (50_000_000),
        .BAUD         (115_200),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .FPGA_CLK1_50 (clk),
        .reset_n      (reset_n),
        .data         (data),
        .start        (start),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse(input logic [7:0] d, input logic par, input int hi, input bit accept);
        @(posedge clk); #1;
        data  = d;
        start = 1'b1;
        if (accept) begin
            exp_q.push_back('{d, par});
            frames_exp++;
        end
        repeat (hi - 1) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check(name, busy, 0);
        @(posedge clk); #1;
    endtask

    // Line monitor: one pass per negedge, samples each bit on its first cycle
    // and requires it to hold for the rest of the bit period.
    initial begin : monitor
        int         cyc;
        bit         in_frame;
        bit         post;
        logic       bits [0:10];
        logic [7:0] got;
        vec_t       e;
        cyc = 0; in_frame = 0; post = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 0;
                post     = 0;
            end else if (!in_frame) begin
                check("idle_done", done, 0);
                if (post) begin
                    check("busy_fall", busy, 0);
                    post = 0;
                end
                if (tx == 1'b0) begin
                    in_frame = 1;
                    cyc      = 0;
                end
            end
            if (in_frame && reset_n) begin
                check("frame_busy", busy, 1);
                check("done_pulse", done, (cyc == FRAME - 1));
                if (cyc % CPB == 0) bits[cyc / CPB] = tx;
                else check("bit_hold", tx, bits[cyc / CPB]);
                if (cyc == FRAME - 1) begin
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[NB - 1], 1);
                    for (int i = 0; i < 8; i++) got[i] = bits[1 + i];
                    frames_rx++;
                    check("frame_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("data", got, e.d);
`ifdef UART_TX_PARITY_EN
                        check("parity", bits[9], e.par);
`endif
                    end
                    in_frame = 0;
                    post     = 1;
                end
                cyc++;
            end
        end
    end

    initial begin : watchdog
        #(50000 * 10);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = '{8'h35, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'hA5, 1'b0};
        vecs[6] = '{8'h31, 1'b1};
        vecs[7] = '{8'h33, 1'b0};

        // Start held high across reset release must not launch a frame.
        reset_n = 1'b0;
        start   = 1'b1;
        data    = 8'h35;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("held_start_tx", tx, 1);
            check("held_start_busy", busy, 0);
        end
        @(posedge clk); #1;
        start = 1'b0;

        // 0x35 frame with a mid-frame rise (0x39) and data toggling after capture.
        @(posedge clk); #1;
        data  = 8'h35;
        start = 1'b1;
        exp_q.push_back('{8'h35, 1'b0});
        frames_exp++;
        @(negedge clk);
        check("lat_pre", tx, 1);
        for (int k = 0; k < 44; k++) begin
            @(posedge clk); #1;
            start = (k < 4) || (k >= 12 && k < 15);
            if (k >= 12 && k < 15) data = 8'h39;
            else data = (k % 2 != 0) ? 8'hFF : 8'h00;
            @(negedge clk);
            if (k == 0) check("lat_fall", tx, 0);
        end
        wait_idle("frame1_idle");
        pulse(8'h39, 1'b0, 5, 1);
        wait_idle("frame2_idle");

        // Rise during the final stop cycle is ignored.
        pulse(8'h7E, 1'b0, 5, 1);
        repeat (FRAME - 4) @(posedge clk);
        #1;
        check("stop_cycle_done", done, 1);
        start = 1'b1;
        data  = 8'h41;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stop_rise_ignored", busy, 0);
        end

        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].d, vecs[i].par, 2, 1);
            wait_idle("vec_idle");
        end

        // Reset in cycle 20 of a frame.
        pulse(8'hA5, 1'b0, 3, 1);
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        frames_exp--;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulse(8'h5A, 1'b0, 3, 1);
        wait_idle("post_rst_idle");

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("frame_count", frames_rx, frames_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
